// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared defaults, read-state enum and bit-reversal helper for the OFDM symbol buffer
package ofdm_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int N_LOG2_DEF   = 6;
  localparam int BITREV_MAX_W = 10;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  // Reverses the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] value,
                                                     input int width);
    bitrev = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) bitrev[width-1-i] = value[i];
    end
  endfunction

endpackage

// File: rtl/ofdm_symbol_buffer_sym_bank.sv
// rtl/ofdm_symbol_buffer_sym_bank.sv - one frame of complex samples, synchronous write, asynchronous read
module sym_bank #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [N_LOG2-1:0]   waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [N_LOG2-1:0]   raddr,
  output logic [2*DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] mem_q [1<<N_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ofdm_symbol_buffer.sv
// rtl/ofdm_symbol_buffer.sv - ping-pong frame buffer between mapper and FFT, natural or bit-reversed drain
module ofdm_symbol_buffer import ofdm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     in_ready,
  input  logic                     bitrev_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     overflow
);

  localparam logic [N_LOG2-1:0] CNT_MAX = '1;

  rd_state_t          state_q, state_d;
  logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [N_LOG2-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]         full_q, full_d;
  logic               bitrev_q, bitrev_d;
  logic               out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic               out_last_q, out_last_d, overflow_q, overflow_d;
  logic [DATA_W-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;

  logic                accept;
  logic                ld, ld_bank, ld_rev;
  logic [N_LOG2-1:0]   ld_cnt, ld_addr;
  logic [2*DATA_W-1:0] wdata, rdata0, rdata1, ld_data;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = in_valid && in_ready;
  assign wdata    = {in_re, in_im};

  sym_bank #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) u_bank0 (
    .clk(clk), .we(accept && !wr_bank_q), .waddr(wr_cnt_q), .wdata(wdata),
    .raddr(ld_addr), .rdata(rdata0)
  );

  sym_bank #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) u_bank1 (
    .clk(clk), .we(accept && wr_bank_q), .waddr(wr_cnt_q), .wdata(wdata),
    .raddr(ld_addr), .rdata(rdata1)
  );

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    bitrev_d    = bitrev_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    overflow_d  = in_valid && !in_ready;
    ld          = 1'b0;
    ld_bank     = rd_bank_q;
    ld_cnt      = rd_cnt_q;
    ld_rev      = bitrev_q;

    if (accept) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_MAX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          ld          = 1'b1;
          ld_cnt      = '0;
          ld_rev      = bitrev_en;
          bitrev_d    = bitrev_en;
          rd_cnt_d    = '0;
          out_valid_d = 1'b1;
          out_first_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = RD_DRAIN;
        end
      end
      default: begin
        if (out_ready) begin
          if (rd_cnt_q != CNT_MAX) begin
            ld          = 1'b1;
            ld_cnt      = rd_cnt_q + 1'b1;
            rd_cnt_d    = rd_cnt_q + 1'b1;
            out_first_d = 1'b0;
            out_last_d  = (rd_cnt_q + 1'b1) == CNT_MAX;
          end else begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            out_first_d       = 1'b0;
            out_last_d        = 1'b0;
            // Chain straight into the other bank so back-to-back frames stream gaplessly.
            if (full_q[!rd_bank_q]) begin
              ld          = 1'b1;
              ld_bank     = !rd_bank_q;
              ld_cnt      = '0;
              ld_rev      = bitrev_en;
              bitrev_d    = bitrev_en;
              rd_cnt_d    = '0;
              out_first_d = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              state_d     = RD_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    ld_addr  = ld_rev ? N_LOG2'(bitrev(BITREV_MAX_W'(ld_cnt), N_LOG2)) : ld_cnt;
    ld_data  = ld_bank ? rdata1 : rdata0;
    out_re_d = ld ? ld_data[2*DATA_W-1:DATA_W] : out_re_q;
    out_im_d = ld ? ld_data[DATA_W-1:0] : out_im_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RD_IDLE;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      bitrev_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      bitrev_q    <= bitrev_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: doc/ofdm_symbol_buffer.md
# ofdm_symbol_buffer

Parametrised, double-buffered (ping-pong) complex-sample framer that sits between the modulator/mapper and the FFT/IFFT core. It collects frames of 2^N_LOG2 samples and streams each completed frame out under a valid/ready handshake, in natural or bit-reversed order. Because it has two banks, frame k+1 is accepted while frame k drains. It also reports back-pressure and dropped samples.

## Interface
Parameters:
- DATA_W, 16: signed width of each of the real and imaginary components.
- N_LOG2, 6: log2 of frame length. N = 2^N_LOG2 samples per frame; legal range 2..10.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample present.
- in_re, in_im  in  DATA_W  signed sample.
- in_ready  out  1  the current write bank is not full.
- bitrev_en  in  1  output order select; sampled when a frame starts draining.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts the sample.
- out_re, out_im  out  DATA_W  signed output sample.
- out_first  out  1  high with the frame's first output sample.
- out_last  out  1  high with the frame's last output sample.
- overflow  out  1  one-cycle pulse: sample dropped because in_valid was high while in_ready was low.

## Operation
- Two banks of N entries each. Each bank has a full flag. Pointers: wr_bank, wr_cnt[N_LOG2-1:0], rd_bank, rd_cnt[N_LOG2-1:0]. The read engine is in one of two states, IDLE or DRAIN.
- Write path:
  - A sample is accepted when in_valid && in_ready.
  - The accepted sample is stored at bank[wr_bank][wr_cnt], and wr_cnt increments.
  - On the accept with wr_cnt == N-1: full[wr_bank] is set, wr_bank toggles, and wr_cnt wraps to 0.
- in_ready = !full[wr_bank]. It is driven from registered flags, with no combinational path from out_ready.
- in_valid && !in_ready: the sample is discarded, overflow pulses for 1 cycle, and no counter changes.
- Read FSM, IDLE:
  - If full[rd_bank], load out_re/out_im from address a0 of rd_bank, and assert out_valid and out_first.
  - Latch the order mode from bitrev_en. Go to DRAIN with rd_cnt = 0.
- Read FSM, DRAIN:
  - The address for rd_cnt is rd_cnt in natural mode, or the N_LOG2-bit reversal of rd_cnt in bit-reversed mode.
  - On a handshake (out_valid && out_ready) with rd_cnt < N-1: rd_cnt increments, the next sample loads into the output registers, and out_first drops. out_last = (rd_cnt == N-1 after the increment).
  - On a handshake with rd_cnt == N-1: clear full[rd_bank] and toggle rd_bank.
    - If the other bank is full, the next frame starts in the following cycle with no gap: its first sample loads, out_first is set, and a fresh bitrev_en sample is latched.
    - Otherwise the FSM goes to IDLE and out_valid drops.
- When out_valid && !out_ready, out_re, out_im, out_first and out_last hold stable.
- Full-flag set (writer) and clear (reader) always target different banks, so they never conflict. A bank freed by the reader is visible to in_ready in the next cycle.
- Samples pass through unmodified: no scaling, rounding or sign extension.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=out_im=0, out_first=out_last=0, overflow=0. Also wr_bank=rd_bank=0, counters 0, both full flags 0, FSM in IDLE. Bank contents are not reset.
- Reset mid-frame discards all partial and full frames. The first sample after reset is index 0 of bank 0.
- Latency: the final sample of a frame is accepted at edge k. full is set at edge k. The first output sample is registered at edge k+1, so out_valid is visible from cycle k+1.
- Throughput: 1 sample/cycle sustained in both directions with continuous in_valid and out_ready.

## Structure
- Shared package ofdm_pkg:
  - DATA_W and N_LOG2 defaults.
  - a bitrev(value, width) function.
  - an enum for read states {RD_IDLE, RD_DRAIN}.
- Sub-module sym_bank: one N×(2·DATA_W) register array with synchronous write and asynchronous read. It is instantiated twice.
- The top module holds the counters, flags, FSM and output registers.

## Test plan
- N_LOG2=6, DATA_W=16. Drive 64 samples with re=i, im=-i, continuous in_valid and out_ready.
  - out_valid rises 1 cycle after the 64th accept.
  - Output is re=0..63, with out_first on 0 and out_last on 63.
- bitrev_en=1 at frame start: output re sequence is 0,32,16,48,8,… ending at 63, with out_last on 63.
- Three back-to-back frames with out_ready=0 until the third frame is presented:
  - in_ready drops after frame 2 fills.
  - Each of 5 extra samples pulses overflow and is dropped.
  - Frames 1 and 2 then drain intact.
- Random out_ready (50%) and continuous input:
  - Data is stable while stalled.
  - No sample is lost or duplicated across 10 frames.
  - Frame boundaries are gapless whenever the next bank is full.
- Assert reset at input sample 30 of frame 2 while frame 1 is half drained:
  - Next cycle: out_valid=0, in_ready=1.
  - A fresh 64-sample frame then emerges correctly.
- Toggle bitrev_en mid-drain: the current frame keeps its order, and the next frame uses the value sampled at its start.
